// File: rtl/uart_cmd_rx_if.sv
// Command-output bundle of uart_cmd_rx: decoded command, sticky error flags and their clear.
interface uart_cmd_rx_if #(
  parameter int unsigned W = 16
);
  logic         cmd_valid;
  logic [1:0]   cmd_ch;
  logic [W-1:0] cmd_value;
  logic         frame_err;
  logic         csum_err;
  logic         err_clr;

  modport master (
    output cmd_valid, cmd_ch, cmd_value, frame_err, csum_err,
    input  err_clr
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_value, frame_err, csum_err,
    output err_clr
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1 byte receiver feeding a 0xA5-framed channel/value parser.
// Optional checksum byte and csum_err flag are compiled in with `define UART_CMD_CHECKSUM_EN.
module uart_cmd_rx #(
  parameter int unsigned W            = 16,
  parameter int unsigned DIV          = 12,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_i,
  uart_cmd_rx_if.master bus
);
  localparam int unsigned CW       = $clog2(DIV);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * DIV;
  localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {
    P_SYNC, P_CH, P_HI, P_LO
`ifdef UART_CMD_CHECKSUM_EN
    , P_CSUM
`endif
  } par_state_t;

  rx_state_t  rx_state_q, rx_state_d;
  par_state_t par_state_q, par_state_d;

  logic          sync1_q, sync2_q, rx_prev_q, armed_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic [TW-1:0] to_cnt_q;
  logic [1:0]    ch_q;
  logic [7:0]    hi_q;
  logic [15:0]   value_c;
  logic          cmd_valid_q, frame_err_q;
  logic [1:0]    cmd_ch_q;
  logic [W-1:0]  cmd_value_q;

  logic rx_s, start_edge_c, tick_half_c, tick_bit_c, timeout_c;
  logic cnt_clr_c, shift_c, byte_stb_c, stop_bad_c, accept_c;

  assign rx_s         = sync2_q;
  assign start_edge_c = armed_q & rx_prev_q & ~rx_s;
  assign tick_half_c  = (cnt_q == CW'(DIV / 2 - 1));
  assign tick_bit_c   = (cnt_q == CW'(DIV - 1));
  assign timeout_c    = (par_state_q != P_SYNC) && (to_cnt_q == TW'(TO_LIMIT));

  // Synchronizer; fill_q marks when sync2_q holds a real line sample, so the
  // reset value of the flops never counts as having seen the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_q | (fill_q[1] & sync2_q);
    end
  end

  // Byte receiver: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state_q <= R_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  // Byte receiver: next state
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      R_IDLE:  if (start_edge_c) rx_state_d = R_START;
      R_START: if (tick_half_c)  rx_state_d = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (tick_bit_c && bit_idx_q == 3'd7) rx_state_d = R_STOP;
      R_STOP:  if (tick_bit_c)   rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Byte receiver: control strobes
  always_comb begin
    cnt_clr_c  = 1'b0;
    shift_c    = 1'b0;
    byte_stb_c = 1'b0;
    stop_bad_c = 1'b0;
    case (rx_state_q)
      R_IDLE:  cnt_clr_c = 1'b1;
      R_START: cnt_clr_c = tick_half_c;
      R_DATA: begin
        cnt_clr_c = tick_bit_c;
        shift_c   = tick_bit_c;
      end
      R_STOP: begin
        cnt_clr_c  = tick_bit_c;
        byte_stb_c = tick_bit_c & rx_s;
        stop_bad_c = tick_bit_c & ~rx_s;
      end
      default: cnt_clr_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
    end else begin
      cnt_q <= cnt_clr_c ? '0 : cnt_q + CW'(1);
      if (shift_c) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        shreg_q   <= {rx_s, shreg_q[7:1]};
      end
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] lo_q, csum_q;
  logic       csum_bad_c, csum_err_q;
  assign value_c = {hi_q, lo_q};
`else
  assign value_c = {hi_q, shreg_q};
`endif

  // Frame parser: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_state_q <= P_SYNC;
    else        par_state_q <= par_state_d;
  end

  // Frame parser: next state; a bad stop bit or an idle timeout drops the frame
  always_comb begin
    par_state_d = par_state_q;
    if (stop_bad_c) begin
      par_state_d = P_SYNC;
    end else if (byte_stb_c) begin
      case (par_state_q)
        P_SYNC: if (shreg_q == SYNC_BYTE) par_state_d = P_CH;
        P_CH:   par_state_d = (shreg_q[7:2] == 6'd0) ? P_HI : P_SYNC;
        P_HI:   par_state_d = P_LO;
`ifdef UART_CMD_CHECKSUM_EN
        P_LO:   par_state_d = P_CSUM;
        P_CSUM: par_state_d = P_SYNC;
`else
        P_LO:   par_state_d = P_SYNC;
`endif
        default: par_state_d = P_SYNC;
      endcase
    end else if (timeout_c) begin
      par_state_d = P_SYNC;
    end
  end

  // Frame parser: acceptance decision
  always_comb begin
    accept_c = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_bad_c = 1'b0;
    if (byte_stb_c && par_state_q == P_CSUM) begin
      accept_c   = (shreg_q == csum_q);
      csum_bad_c = (shreg_q != csum_q);
    end
`else
    if (byte_stb_c && par_state_q == P_LO) accept_c = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q     <= '0;
      hi_q     <= '0;
      to_cnt_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      lo_q     <= '0;
      csum_q   <= '0;
`endif
    end else begin
      if (byte_stb_c) begin
        case (par_state_q)
          P_CH: begin
            ch_q <= shreg_q[1:0];
`ifdef UART_CMD_CHECKSUM_EN
            csum_q <= shreg_q;
`endif
          end
          P_HI: begin
            hi_q <= shreg_q;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q <= csum_q ^ shreg_q;
`endif
          end
`ifdef UART_CMD_CHECKSUM_EN
          P_LO: begin
            lo_q   <= shreg_q;
            csum_q <= csum_q ^ shreg_q;
          end
`endif
          default: ;
        endcase
      end
      // Idle timer: runs only mid-frame, restarts on every received byte
      if (par_state_q == P_SYNC || byte_stb_c) to_cnt_q <= '0;
      else if (to_cnt_q != TW'(TO_LIMIT))      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  // Command outputs and sticky flags (a set in the same cycle as err_clr wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_ch_q    <= '0;
      cmd_value_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= accept_c;
      if (accept_c) begin
        cmd_ch_q    <= ch_q;
        cmd_value_q <= value_c[15 -: W];
      end
      frame_err_q <= stop_bad_c | (frame_err_q & ~bus.err_clr);
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_err_q <= 1'b0;
    else        csum_err_q <= csum_bad_c | (csum_err_q & ~bus.err_clr);
  end
  assign bus.csum_err = csum_err_q;
`else
  assign bus.csum_err = 1'b0;
`endif

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_ch    = cmd_ch_q;
  assign bus.cmd_value = cmd_value_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed self-checking bench for uart_cmd_rx (DIV=12, W=16); adapts frames to UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_rx;
  localparam int unsigned DIV = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_i;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0;
  logic fe_seen = 1'b0;

  uart_cmd_rx_if #(.W(16)) bus ();

  uart_cmd_rx #(.W(16), .DIV(DIV), .TIMEOUT_BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_i  (rx_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) valid_cnt++;
    if (bus.frame_err === 1'b1) fe_seen = 1'b1;
  end

  task automatic uart_bit(input logic v);
    rx_i = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(8'hA5, 1'b1);
    send_byte(ch, 1'b1);
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(ch ^ hi ^ lo, 1'b1);
`endif
  endtask

  task automatic idle(input int bits);
    rx_i = 1'b1;
    repeat (bits * DIV) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_i = 1'b1; bus.err_clr = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.cmd_valid); end
    n_checks++; if (bus.cmd_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %h exp 0", bus.cmd_ch); end
    n_checks++; if (bus.cmd_value !== 16'h0000) begin n_fail++; $display("FAIL reset_value got %h exp 0000", bus.cmd_value); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", bus.frame_err); end
    n_checks++; if (bus.csum_err !== 1'b0) begin n_fail++; $display("FAIL reset_csum_err got %b exp 0", bus.csum_err); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_valid_frame;
    int v0 = valid_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'hB1, 1'b1); send_byte(8'hE0, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h53, 1'b1);
`endif
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL valid_pulses got %0d exp 1", valid_cnt - v0); end
    n_checks++; if (bus.cmd_ch !== 2'd2) begin n_fail++; $display("FAIL valid_ch got %h exp 2", bus.cmd_ch); end
    n_checks++; if (bus.cmd_value !== 16'hB1E0) begin n_fail++; $display("FAIL valid_value got %h exp b1e0", bus.cmd_value); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL valid_frame_err got %b exp 0", bus.frame_err); end
    n_checks++; if (bus.csum_err !== 1'b0) begin n_fail++; $display("FAIL valid_csum_err got %b exp 0", bus.csum_err); end
  endtask

  task automatic test_max_value;
    int v0 = valid_cnt;
    send_frame(8'h00, 8'h7F, 8'hFF);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL max_pulses got %0d exp 1", valid_cnt - v0); end
    n_checks++; if (bus.cmd_ch !== 2'd0) begin n_fail++; $display("FAIL max_ch got %h exp 0", bus.cmd_ch); end
    n_checks++; if (bus.cmd_value !== 16'h7FFF) begin n_fail++; $display("FAIL max_value got %h exp 7fff", bus.cmd_value); end
  endtask

  task automatic test_bad_channel;
    int v0 = valid_cnt;
    send_frame(8'h04, 8'h11, 8'h22);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 0) begin n_fail++; $display("FAIL badch_pulses got %0d exp 0", valid_cnt - v0); end
    n_checks++; if (bus.cmd_value !== 16'h7FFF) begin n_fail++; $display("FAIL badch_value got %h exp 7fff", bus.cmd_value); end
    n_checks++; if (bus.csum_err !== 1'b0) begin n_fail++; $display("FAIL badch_csum_err got %b exp 0", bus.csum_err); end
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic test_checksum;
    int v0 = valid_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h4E, 1'b1);
    send_byte(8'h20, 1'b1); send_byte(8'h00, 1'b1);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 0) begin n_fail++; $display("FAIL csum_pulses got %0d exp 0", valid_cnt - v0); end
    n_checks++; if (bus.csum_err !== 1'b1) begin n_fail++; $display("FAIL csum_err_set got %b exp 1", bus.csum_err); end
    n_checks++; if (bus.cmd_ch !== 2'd0 || bus.cmd_value !== 16'h7FFF) begin n_fail++; $display("FAIL csum_unchanged got %h/%h exp 0/7fff", bus.cmd_ch, bus.cmd_value); end
    bus.err_clr = 1'b1; @(negedge clk); bus.err_clr = 1'b0; @(negedge clk);
    n_checks++; if (bus.csum_err !== 1'b0) begin n_fail++; $display("FAIL csum_err_clr got %b exp 0", bus.csum_err); end
  endtask
`endif

  task automatic test_framing;
    int v0;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b0);
    idle(2);
    n_checks++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set got %b exp 1", bus.frame_err); end
    bus.err_clr = 1'b1; @(negedge clk); bus.err_clr = 1'b0; @(negedge clk);
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_err_clr got %b exp 0", bus.frame_err); end
    // err_clr held across the error event: the flag must still get set
    fe_seen = 1'b0;
    bus.err_clr = 1'b1;
    send_byte(8'h33, 1'b0);
    idle(1);
    bus.err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (fe_seen !== 1'b1) begin n_fail++; $display("FAIL frame_set_wins got %b exp 1", fe_seen); end
    v0 = valid_cnt;
    send_frame(8'h03, 8'h12, 8'h34);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL frame_after_pulses got %0d exp 1", valid_cnt - v0); end
    n_checks++; if (bus.cmd_ch !== 2'd3 || bus.cmd_value !== 16'h1234) begin n_fail++; $display("FAIL frame_after_cmd got %h/%h exp 3/1234", bus.cmd_ch, bus.cmd_value); end
  endtask

  task automatic test_timeout;
    int v0 = valid_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1);
    idle(33);
    send_byte(8'h4E, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h4C, 1'b1);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 0) begin n_fail++; $display("FAIL timeout_pulses got %0d exp 0", valid_cnt - v0); end
    n_checks++; if (bus.frame_err !== 1'b0 || bus.csum_err !== 1'b0) begin n_fail++; $display("FAIL timeout_flags got %b%b exp 00", bus.frame_err, bus.csum_err); end
    // Gap well under the timeout keeps the frame alive
    v0 = valid_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
    idle(20);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h24, 1'b1);
`endif
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1 || bus.cmd_ch !== 2'd2) begin n_fail++; $display("FAIL short_gap got %0d/%h exp 1/2", valid_cnt - v0, bus.cmd_ch); end
    v0 = valid_cnt;
    send_frame(8'h01, 8'h00, 8'h80);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1 || bus.cmd_value !== 16'h0080) begin n_fail++; $display("FAIL timeout_next got %0d/%h exp 1/0080", valid_cnt - v0, bus.cmd_value); end
  endtask

  task automatic test_glitch;
    int v0 = valid_cnt;
    send_byte(8'hA5, 1'b1);
    idle(1);
    rx_i = 1'b0; repeat (3) @(negedge clk); rx_i = 1'b1;
    idle(12);
    send_byte(8'h01, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hFE, 1'b1);
`endif
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL glitch_pulses got %0d exp 1", valid_cnt - v0); end
    n_checks++; if (bus.cmd_ch !== 2'd1 || bus.cmd_value !== 16'h55AA) begin n_fail++; $display("FAIL glitch_cmd got %h/%h exp 1/55aa", bus.cmd_ch, bus.cmd_value); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err got %b exp 0", bus.frame_err); end
  endtask

  task automatic test_reset_mid;
    int v0 = valid_cnt;
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    uart_bit(1'b0); uart_bit(1'b1); uart_bit(1'b0);
    rst_n = 1'b0; rx_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.cmd_ch !== 2'd0 || bus.cmd_value !== 16'h0000) begin n_fail++; $display("FAIL rstmid_cmd got %h/%h exp 0/0000", bus.cmd_ch, bus.cmd_value); end
    n_checks++; if (bus.cmd_valid !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got %b%b exp 00", bus.cmd_valid, bus.frame_err); end
    // Line held low across release: no start may be taken before it is seen high
    rst_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    idle(12);
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_low_line got %b exp 0", bus.frame_err); end
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    idle(2);
    n_checks++; if (valid_cnt != v0) begin n_fail++; $display("FAIL rstmid_pulses got %0d exp 0", valid_cnt - v0); end
    send_frame(8'h02, 8'hB1, 8'hE0);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 1 || bus.cmd_value !== 16'hB1E0) begin n_fail++; $display("FAIL rstmid_next got %0d/%h exp 1/b1e0", valid_cnt - v0, bus.cmd_value); end
  endtask

  task automatic test_back_to_back;
    int v0 = valid_cnt;
    send_frame(8'h03, 8'hC0, 8'h01);
    send_frame(8'h00, 8'h7F, 8'hFF);
    send_frame(8'h01, 8'h80, 8'h00);
    idle(2);
    n_checks++; if (valid_cnt - v0 != 3) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 3", valid_cnt - v0); end
    n_checks++; if (bus.cmd_ch !== 2'd1) begin n_fail++; $display("FAIL b2b_ch got %h exp 1", bus.cmd_ch); end
    n_checks++; if (bus.cmd_value !== 16'h8000) begin n_fail++; $display("FAIL b2b_value got %h exp 8000", bus.cmd_value); end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_max_value();
    test_bad_channel();
`ifdef UART_CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_framing();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
